// File: rtl/uart_cmd_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_cmd_if
// Purpose  : Host-side 8N1 UART front end. Receives bytes on rx_i and packs
//            byte pairs into a 16-bit command word (first byte high) with a
//            cmd_rdy_o / clr_cmd_rdy_i handshake. Serializes a response byte
//            on tx_o when send_resp_i is accepted and pulses resp_sent_o when
//            the frame completes. RX and TX run independently.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            rx_i / tx_o       - serial in (async, idles high) / serial out
//            cmd_o, cmd_rdy_o  - assembled command and its valid flag
//            clr_cmd_rdy_i     - single-cycle clear of cmd_rdy_o
//            resp_i, send_resp_i, resp_sent_o - response byte, request, done
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_if #(
  parameter int BAUD_DIV = 1736
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        tx_o,
  output logic [15:0] cmd_o,
  output logic        cmd_rdy_o,
  input  logic        clr_cmd_rdy_i,
  input  logic [7:0]  resp_i,
  input  logic        send_resp_i,
  output logic        resp_sent_o
);

  localparam int                 c_CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(BAUD_DIV);
  localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(BAUD_DIV / 2);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  // --------------------------------------------------------------------------
  // RX synchronizer (idle level is high, so reset to 1)
  // --------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // RX framing FSM. The counter counts down from its load value; a value of 1
  // marks expiry, so a load of N produces a sample exactly N edges later.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t          rx_state_q;
  logic [c_CNT_W-1:0] rx_cnt_q;
  logic [2:0]         rx_bit_q;
  logic [7:0]         rx_shift_q;
  logic               byte_vld_q;
  logic               w_rx_tick;

  assign w_rx_tick = (rx_cnt_q == c_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s_q) begin
            rx_cnt_q   <= c_HALF;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (w_rx_tick) begin
            // Line back high at mid start bit: treat as a glitch.
            if (rx_s_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_cnt_q   <= c_FULL;
              rx_bit_q   <= '0;
              rx_state_q <= RX_DATA;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - c_ONE;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            rx_shift_q <= {rx_s_q, rx_shift_q[7:1]};
            rx_cnt_q   <= c_FULL;
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - c_ONE;
          end
        end
        RX_STOP: begin
          if (w_rx_tick) begin
            // A low stop bit is a framing error: the byte is silently dropped.
            byte_vld_q <= rx_s_q;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - c_ONE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Command assembly. A byte arriving while cmd_rdy is still set is dropped,
  // even when the clear arrives in the same cycle. rx_shift_q is stable while
  // byte_vld_q is high because the RX FSM is back in IDLE.
  // --------------------------------------------------------------------------
  typedef enum logic {ASM_WAIT_HI, ASM_WAIT_LO} asm_state_t;

  asm_state_t  asm_state_q;
  logic [7:0]  hi_q;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state_q <= ASM_WAIT_HI;
      hi_q        <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
    end else begin
      if (clr_cmd_rdy_i) begin
        cmd_rdy_q <= 1'b0;
      end
      if (byte_vld_q && !cmd_rdy_q) begin
        case (asm_state_q)
          ASM_WAIT_HI: begin
            hi_q        <= rx_shift_q;
            asm_state_q <= ASM_WAIT_LO;
          end
          ASM_WAIT_LO: begin
            cmd_q       <= {hi_q, rx_shift_q};
            cmd_rdy_q   <= 1'b1;
            asm_state_q <= ASM_WAIT_HI;
          end
          default: asm_state_q <= ASM_WAIT_HI;
        endcase
      end
    end
  end

  assign cmd_o     = cmd_q;
  assign cmd_rdy_o = cmd_rdy_q;

  // --------------------------------------------------------------------------
  // TX FSM. tx_o is bit 0 of the frame register; ones shift in from the top,
  // so the register is all ones (line idle) whenever no frame is in flight.
  // --------------------------------------------------------------------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t          tx_state_q;
  logic [9:0]         tx_shift_q;
  logic [c_CNT_W-1:0] tx_cnt_q;
  logic [3:0]         tx_bit_q;
  logic               resp_sent_q;
  logic               w_tx_tick;

  assign w_tx_tick = (tx_cnt_q == c_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      resp_sent_q <= 1'b0;
    end else begin
      resp_sent_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (send_resp_i) begin
            tx_shift_q <= {1'b1, resp_i, 1'b0};
            tx_cnt_q   <= c_FULL;
            tx_bit_q   <= '0;
            tx_state_q <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (w_tx_tick) begin
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            tx_cnt_q   <= c_FULL;
            if (tx_bit_q == 4'd9) begin
              tx_state_q  <= TX_IDLE;
              resp_sent_q <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - c_ONE;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_o        = tx_shift_q[0];
  assign resp_sent_o = resp_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_if
// Purpose  : Self-checking bench for uart_cmd_if at BAUD_DIV=16. Received
//            bytes are tracked by a transaction-level command model; response
//            frames are checked cycle by cycle against the ideal 8N1 waveform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_if;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        tx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  uart_cmd_if #(.BAUD_DIV(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_i          (rx),
    .tx_o          (tx),
    .cmd_o         (cmd),
    .cmd_rdy_o     (cmd_rdy),
    .clr_cmd_rdy_i (clr),
    .resp_i        (resp),
    .send_resp_i   (send_resp),
    .resp_sent_o   (resp_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Command-path model: pending high byte, last command, ready flag.
  bit          m_have_hi;
  logic [7:0]  m_hi;
  logic [15:0] m_cmd;
  bit          m_rdy;

  function automatic void model_reset();
    m_have_hi = 0; m_hi = '0; m_cmd = '0; m_rdy = 0;
  endfunction

  // clr_same: the consumer's clear coincided with this byte's arrival.
  function automatic void model_byte(input logic [7:0] b, input bit stop_ok, input bit clr_same);
    if (!stop_ok) return;
    if (m_rdy) begin
      if (clr_same) m_rdy = 0;
    end else if (m_have_hi) begin
      m_cmd = {m_hi, b}; m_rdy = 1; m_have_hi = 0;
    end else begin
      m_hi = b; m_have_hi = 1;
    end
  endfunction

  task automatic check_cmd_state(input string tag);
    @(negedge clk);
    check({tag, "_rdy"}, cmd_rdy, m_rdy);
    check({tag, "_cmd"}, cmd, m_cmd);
  endtask

  // Send one 8N1 frame; clr_at >= 0 pulses the clear during that bit-cycle.
  task automatic uart_send(input logic [7:0] b, input bit stop_ok, input int clr_at);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    @(posedge clk);
    for (int c = 0; c < 10 * N; c++) begin
      #1 rx = fr[c / N];
      clr = (c == clr_at);
      @(posedge clk);
    end
    #1 rx = 1'b1; clr = 1'b0;
    repeat (N) @(posedge clk);
    model_byte(b, stop_ok, clr_at >= 0);
    check_cmd_state("rx_byte");
  endtask

  task automatic clear_rdy();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    m_rdy = 0;
    check_cmd_state("clear");
  endtask

  task automatic false_start(input int len);
    @(posedge clk);
    for (int c = 0; c < len; c++) begin
      #1 rx = 1'b0;
      @(posedge clk);
    end
    #1 rx = 1'b1;
    repeat (2 * N) @(posedge clk);
    check_cmd_state("glitch");
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(posedge clk); #1 resp = b; send_resp = 1'b1;
    @(posedge clk); #1 send_resp = 1'b0;
  endtask

  // Called just after the accepting edge (edge 0). Checks cycles 1..10N+1.
  task automatic check_frame(input logic [7:0] b, input bit poke, input bit chain, input logic [7:0] nb);
    logic [9:0] fr;
    logic       e;
    fr   = {1'b1, b, 1'b0};
    resp = 8'($urandom);
    for (int c = 1; c <= 10 * N + 1; c++) begin
      @(negedge clk);
      e = (c <= 10 * N) ? fr[(c - 1) / N] : 1'b1;
      check("tx_bit", tx, e);
      check("resp_sent", resp_sent, (c == 10 * N + 1));
      if (poke && c == 80) begin resp = ~b; send_resp = 1'b1; end
      if (chain && c == 10 * N + 1) begin resp = nb; send_resp = 1'b1; end
      @(posedge clk); #1 send_resp = 1'b0;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         pulses;
    logic [9:0] fr;
    rst = 1'b1; rx = 1'b1; clr = 1'b0; send_resp = 1'b0; resp = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_rdy", cmd_rdy, 1'b0);
    check("rst_resp_sent", resp_sent, 1'b0);

    // Basic command
    uart_send(8'h41, 1, -1);
    uart_send(8'h23, 1, -1);
    check("basic_cmd", cmd, 16'h4123);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("basic_hold", cmd_rdy, 1'b1);
    clear_rdy();
    check("basic_keep", cmd, 16'h4123);

    // Response frame, ignored mid-frame request, back-to-back frame
    start_tx(8'hA5);
    check_frame(8'hA5, 1, 1, 8'h5C);
    check_frame(8'h5C, 0, 0, 8'h00);

    // Discard while ready, then clear coinciding with a byte
    uart_send(8'h56, 1, -1);
    uart_send(8'h78, 1, -1);
    uart_send(8'h77, 1, -1);
    check("discard_keep", cmd, 16'h5678);
    clear_rdy();
    uart_send(8'h12, 1, -1);
    uart_send(8'h34, 1, -1);
    check("discard_cmd", cmd, 16'h1234);
    uart_send(8'h99, 1, 155);
    check("coincide_rdy", cmd_rdy, 1'b0);

    // False start and framing error
    false_start(4);
    uart_send(8'h40, 1, -1);
    uart_send(8'hC7, 0, -1);
    check("frame_err_rdy", cmd_rdy, 1'b0);
    uart_send(8'h05, 1, -1);
    check("frame_err_cmd", cmd, 16'h4005);
    clear_rdy();

    // RX and TX concurrently
    fork
      begin start_tx(8'h3C); check_frame(8'h3C, 0, 0, 8'h00); end
      begin uart_send(8'hE1, 1, -1); uart_send(8'h0F, 1, -1); end
    join
    check("concurrent_cmd", cmd, 16'hE10F);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: false_start(int'($urandom_range(1, 6)));
        1: uart_send(8'($urandom), 0, -1);
        2: if (m_rdy) clear_rdy();
        3: if (m_rdy) uart_send(8'($urandom), 1, 155);
        default: uart_send(8'($urandom), 1, -1);
      endcase
      if (m_rdy && $urandom_range(0, 1) == 1) clear_rdy();
    end

    // Reset in the middle of a TX frame and an RX byte, with a pending high byte
    if (m_rdy) clear_rdy();
    if (m_have_hi) uart_send(8'h00, 1, -1);
    if (m_rdy) clear_rdy();
    uart_send(8'h11, 1, -1);
    fr = {1'b1, 8'h3C, 1'b0};
    @(posedge clk);
    #1 resp = 8'h5A; send_resp = 1'b1; rx = fr[0];
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      #1 send_resp = 1'b0; rx = fr[c / N];
      if (c == 50) rst = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0; rx = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_rdy", cmd_rdy, 1'b0);
    check("midrst_cmd", cmd, 16'h0000);
    pulses = 0;
    for (int c = 0; c < 12 * N; c++) begin
      @(negedge clk);
      if (resp_sent) pulses++;
    end
    check("midrst_no_resp_sent", pulses, 0);
    uart_send(8'hAA, 1, -1);
    uart_send(8'hBB, 1, -1);
    check("midrst_cmd_aabb", cmd, 16'hAABB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
